mod_addsub_pipe: RTL and testbench
==================================

Name: mod_addsub_pipe

Overview:
- Parametrised, pipelined modular add/subtract unit for NTT/polynomial datapaths.
- Computes (a ± b) mod q on reduced operands.
- Two-stage pipeline with valid/ready handshake on both sides.
- Tag field passes through so the shared unit can be interleaved across channels/coefficient indices.

Parameters:
- W, 23, modulus and operand width (default suits q = 8380417).
- TAG_W, 4, width of the pass-through tag.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- valid_i  in  1  input operation valid.
- ready_o  out  1  unit accepts input this cycle.
- op_i  in  1  0 = add, 1 = subtract (a - b).
- a_i  in  W  operand a, required < q.
- b_i  in  W  operand b, required < q.
- q_i  in  W  modulus, 2 ≤ q < 2^W; sampled per operation.
- tag_i  in  TAG_W  user tag.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts result.
- c_o  out  W  result, always < q.
- tag_o  out  TAG_W  tag of the result.

Behaviour:
- Reset (async assert, sync release): valid_o = 0, c_o = 0, tag_o = 0, both stage valid flags = 0. ready_o is 1 as soon as reset is released.
- Accept rule: an input is accepted on a rising edge when valid_i && ready_o.
- Result rule: a result is consumed on a rising edge when valid_o && ready_i.
- Stage 1 registers:
  - Add: s = a + b, W+1 bits.
  - Sub: s = {1'b0,a} - {1'b0,b}, W+1 bits; the borrow is kept.
  - op, q and tag are registered alongside s.
- Stage 2 (output register) performs the correction:
  - Add: if s ≥ q then c = s - q, else c = s[W-1:0].
  - Sub: if borrow then c = s + q (truncated to W bits), else c = s[W-1:0].
- Latency: 2 cycles from acceptance to valid_o when ready_i stays high. Throughput is 1 op/cycle.
- Stage advance rules:
  - Stage 2 loads when it is empty or its result is consumed this cycle.
  - Stage 1 advances into stage 2 under the same condition.
  - ready_o = !s1_valid || s1_advance. This is combinational from ready_i; no skid buffer.
- Backpressure: with ready_i low, at most 2 ops are held. ready_o falls after both stages fill. Data and tags are held stable while valid_o && !ready_i.
- Ordering: strict in-order. No op is dropped or duplicated.
- Simultaneous events: accept and consume in the same cycle with both stages full is legal and keeps full throughput.
- Boundaries:
  - Add: a = q-1, b = q-1 gives q-2.
  - Sub: a = 0, b = q-1 gives 1.
  - a = b gives 0 in sub mode.
- Reset mid-operation: all in-flight ops are discarded, valid_o drops immediately (asynchronously).
- Out-of-range operands (≥ q) produce an undefined result value, but the handshake remains correct.

Optional Feature:
- Macro: MOD_ADDSUB_RANGE_CHECK_EN.
- When defined:
  - Adds output port err_o (1 bit), reset 0.
  - Stage 1 registers (a ≥ q) || (b ≥ q) and carries it with the op.
  - err_o is valid with valid_o, follows the same handshake, and is cleared when that result is consumed.
- When undefined: no err_o port and no compare logic.

Decomposition:
- Package mod_arith_pkg holds:
  - Q_DILITHIUM = 23'd8380417.
  - op enum (OP_ADD = 1'b0, OP_SUB = 1'b1).
  - Default W and TAG_W constants.
- Natural sub-module: mod_corr_stage, the combinational stage-2 correction (inputs s, borrow, op, q; output c). It reuses subtractor_n for the s - q compare.

Test Plan (q = 8380417):
- Add: a = 5, b = 7, ready_i = 1 → c_o = 12, valid_o exactly 2 cycles after acceptance.
- Add wrap: a = 8380416, b = 1 → 0. Then a = 8380416, b = 8380416 → 8380415.
- Sub borrow: a = 3, b = 5 → 8380415. Then a = 0, b = 0 → 0. Tags 0xA and 0xB are returned in order.
- Backpressure: 4 back-to-back ops with ready_i low from cycle 1 → ready_o low after 2 held. After ready_i rises, all 4 results emerge in order with correct tags and no duplicates.
- Reset: assert rst_n_i with 2 ops in flight → valid_o = 0 at once. After release, a fresh op completes normally.
- MOD_ADDSUB_RANGE_CHECK_EN: a = 8380417, b = 0 → err_o = 1 with its result. A following legal op → err_o = 0.

Source files
------------

// File: rtl/mod_arith_pkg.sv
// Shared constants and types for the modular arithmetic datapath.
package mod_arith_pkg;

  localparam int W_DEF     = 23;
  localparam int TAG_W_DEF = 4;

  localparam logic [22:0] Q_DILITHIUM = 23'd8380417;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

endpackage

// File: rtl/mod_corr_stage.sv
// Combinational modular correction of a raw add/sub result back into [0, q).
module mod_corr_stage
  import mod_arith_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W:0]   s,
  input  logic         borrow,
  input  op_e          op,
  input  logic [W-1:0] q,
  output logic [W-1:0] c
);

  logic [W-1:0] s_minus_q;
  logic         lo_lt_q;
  logic [W-1:0] s_plus_q;

  // s >= q when the carry is set (s >= 2^W > q) or the low W bits already reach q;
  // s - q < q < 2^W, so the W-bit difference is exact.
  subtractor_n #(.N(W)) u_sub (
    .a      (s[W-1:0]),
    .b      (q),
    .diff   (s_minus_q),
    .borrow (lo_lt_q)
  );

  assign s_plus_q = s[W-1:0] + q;

  always_comb begin
    c = s[W-1:0];
    if (op == OP_ADD) begin
      if (s[W] || !lo_lt_q) c = s_minus_q;
    end else begin
      if (borrow) c = s_plus_q;
    end
  end

endmodule

// File: rtl/subtractor_n.sv
// N-bit unsigned subtractor: diff = a - b mod 2^N, borrow set when a < b.
module subtractor_n #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/mod_addsub_pipe.sv
// Two-stage (a +/- b) mod q with valid/ready on both sides; ready_o is combinational from ready_i.
// Optional operand range flag err_o when MOD_ADDSUB_RANGE_CHECK_EN is defined.
module mod_addsub_pipe
  import mod_arith_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             op_i,
  input  logic [W-1:0]     a_i,
  input  logic [W-1:0]     b_i,
  input  logic [W-1:0]     q_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [W-1:0]     c_o,
  output logic [TAG_W-1:0] tag_o
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
  ,
  output logic             err_o
`endif
);

  logic             s1_valid;
  logic [W:0]       s1_s;
  op_e              s1_op;
  logic [W-1:0]     s1_q;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_load;
  logic             s1_advance;
  logic             accept;
  logic [W:0]       s_nxt;
  logic [W-1:0]     c_nxt;

  assign s2_load    = !valid_o || ready_i;
  assign s1_advance = s1_valid && s2_load;
  assign ready_o    = !s1_valid || s1_advance;
  assign accept     = valid_i && ready_o;

  // For subtract the top bit is the borrow of a - b.
  assign s_nxt = (op_e'(op_i) == OP_ADD) ? ({1'b0, a_i} + {1'b0, b_i})
                                         : ({1'b0, a_i} - {1'b0, b_i});

  mod_corr_stage #(.W(W)) u_corr (
    .s      (s1_s),
    .borrow (s1_s[W]),
    .op     (s1_op),
    .q      (s1_q),
    .c      (c_nxt)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid <= 1'b0;
      s1_s     <= '0;
      s1_op    <= OP_ADD;
      s1_q     <= '0;
      s1_tag   <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_s     <= s_nxt;
        s1_op    <= op_e'(op_i);
        s1_q     <= q_i;
        s1_tag   <= tag_i;
      end else if (s1_advance) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_o <= 1'b0;
      c_o     <= '0;
      tag_o   <= '0;
    end else if (s2_load) begin
      valid_o <= s1_valid;
      if (s1_valid) begin
        c_o   <= c_nxt;
        tag_o <= s1_tag;
      end
    end
  end

`ifdef MOD_ADDSUB_RANGE_CHECK_EN
  logic s1_err;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_err <= 1'b0;
      err_o  <= 1'b0;
    end else begin
      if (accept) s1_err <= (a_i >= q_i) || (b_i >= q_i);
      // A bubble entering stage 2 clears the flag of the consumed result.
      if (s2_load) err_o <= s1_valid && s1_err;
    end
  end
`endif

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Directed bench for mod_addsub_pipe: hand-computed vectors, in-order scoreboard on the output side.
module tb_mod_addsub_pipe;
  import mod_arith_pkg::*;

  localparam int W     = 23;
  localparam int TAG_W = 4;
  localparam logic [W-1:0] Q    = Q_DILITHIUM;
  localparam logic [W-1:0] QMAX = 23'd8388607;

  logic             clk_i;
  logic             rst_n_i;
  logic             valid_i;
  logic             ready_o;
  logic             op_i;
  logic [W-1:0]     a_i;
  logic [W-1:0]     b_i;
  logic [W-1:0]     q_i;
  logic [TAG_W-1:0] tag_i;
  logic             valid_o;
  logic             ready_i;
  logic [W-1:0]     c_o;
  logic [TAG_W-1:0] tag_o;
  logic             err_o;

  typedef struct {
    logic [W-1:0]     c;
    logic [TAG_W-1:0] tag;
    logic             err;
    logic             chk_c;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  mod_addsub_pipe #(.W(W), .TAG_W(TAG_W)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .op_i    (op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .q_i     (q_i),
    .tag_i   (tag_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .c_o     (c_o),
    .tag_o   (tag_o)
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
    ,
    .err_o   (err_o)
`endif
  );

`ifndef MOD_ADDSUB_RANGE_CHECK_EN
  assign err_o = 1'b0;
`endif

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Output monitor: a result shown with ready_i high is consumed at the next edge.
  always @(negedge clk_i) begin
    if (rst_n_i && valid_o && ready_i) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 32'(tag_o), 32'hFFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("res_tag", 32'(tag_o), 32'(e.tag));
        if (e.chk_c) chk("res_c", 32'(c_o), 32'(e.c));
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
        chk("res_err", 32'(err_o), 32'(e.err));
`endif
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after acceptance with valid_i still high.
  task automatic send(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] q, input logic [TAG_W-1:0] tag,
                      input logic [W-1:0] c, input logic err, input logic chk_c);
    bit   ok;
    exp_t e;
    ok      = 1'b0;
    valid_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    q_i     = q;
    tag_i   = tag;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 32'(ok), 32'd1);
    else begin
      e.c = c; e.tag = tag; e.err = err; e.chk_c = chk_c;
      exp_q.push_back(e);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk_i);
    #1;
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst_n_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    op_i    = 1'b0;
    a_i     = '0;
    b_i     = '0;
    q_i     = Q;
    tag_i   = '0;

    #1;
    chk("rst_valid_o", 32'(valid_o), 32'd0);
    chk("rst_c_o", 32'(c_o), 32'd0);
    chk("rst_tag_o", 32'(tag_o), 32'd0);
`ifdef MOD_ADDSUB_RANGE_CHECK_EN
    chk("rst_err_o", 32'(err_o), 32'd0);
`endif
    @(posedge clk_i);
    @(posedge clk_i);
    #3 rst_n_i = 1'b1;
    @(negedge clk_i);
    chk("rst_ready_o", 32'(ready_o), 32'd1);
    @(posedge clk_i);
    #1;

    // Latency: result appears in the second cycle after the accepting edge.
    send(OP_ADD, 23'd5, 23'd7, Q, 4'h1, 23'd12, 1'b0, 1'b1);
    idle();
    @(negedge clk_i);
    chk("lat_cycle1_valid", 32'(valid_o), 32'd0);
    @(negedge clk_i);
    chk("lat_cycle2_valid", 32'(valid_o), 32'd1);
    chk("lat_cycle2_c", 32'(c_o), 32'd12);
    @(posedge clk_i);
    #1;

    send(OP_ADD, Q - 23'd1, 23'd1, Q, 4'h2, 23'd0, 1'b0, 1'b1);
    send(OP_ADD, Q - 23'd1, Q - 23'd1, Q, 4'h3, 23'd8380415, 1'b0, 1'b1);
    send(OP_SUB, 23'd3, 23'd5, Q, 4'hA, 23'd8380415, 1'b0, 1'b1);
    send(OP_SUB, 23'd0, 23'd0, Q, 4'hB, 23'd0, 1'b0, 1'b1);
    send(OP_SUB, 23'd12345, 23'd12345, Q, 4'hC, 23'd0, 1'b0, 1'b1);
    send(OP_SUB, 23'd0, Q - 23'd1, Q, 4'hD, 23'd1, 1'b0, 1'b1);
    send(OP_ADD, 23'd1, 23'd1, 23'd2, 4'h5, 23'd0, 1'b0, 1'b1);
    send(OP_ADD, QMAX - 23'd1, QMAX - 23'd1, QMAX, 4'h6, 23'd8388605, 1'b0, 1'b1);
    send(OP_SUB, 23'd0, QMAX - 23'd1, QMAX, 4'h7, 23'd1, 1'b0, 1'b1);
    idle();
    wait_drain("drain_basic");

    // Backpressure: two ops held, third stalls, then all four drain in order.
    ready_i = 1'b0;
    send(OP_ADD, 23'd100, 23'd200, Q, 4'h4, 23'd300, 1'b0, 1'b1);
    send(OP_SUB, 23'd10, 23'd20, Q, 4'h5, 23'd8380407, 1'b0, 1'b1);
    op_i = OP_ADD; a_i = 23'd8380000; b_i = 23'd1000; tag_i = 4'h6;
    @(negedge clk_i);
    chk("bp_ready_low", 32'(ready_o), 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    chk("bp_hold_valid", 32'(valid_o), 32'd1);
    chk("bp_hold_c", 32'(c_o), 32'd300);
    chk("bp_hold_tag", 32'(tag_o), 32'd4);
    chk("bp_ready_still_low", 32'(ready_o), 32'd0);
    @(posedge clk_i);
    #1;
    ready_i = 1'b1;
    send(OP_ADD, 23'd8380000, 23'd1000, Q, 4'h6, 23'd583, 1'b0, 1'b1);
    send(OP_SUB, 23'd7, 23'd7, Q, 4'h7, 23'd0, 1'b0, 1'b1);
    idle();
    wait_drain("drain_bp");
    @(negedge clk_i);
    chk("bp_idle_valid", 32'(valid_o), 32'd0);
    @(posedge clk_i);
    #1;

    // Reset with two ops in flight.
    send(OP_ADD, 23'd1, 23'd2, Q, 4'h8, 23'd3, 1'b0, 1'b1);
    send(OP_ADD, 23'd3, 23'd4, Q, 4'h9, 23'd7, 1'b0, 1'b1);
    idle();
    #2 rst_n_i = 1'b0;
    #1;
    chk("midrst_valid_o", 32'(valid_o), 32'd0);
    exp_q.delete();
    @(posedge clk_i);
    #3 rst_n_i = 1'b1;
    @(negedge clk_i);
    chk("postrst_valid_o", 32'(valid_o), 32'd0);
    chk("postrst_ready_o", 32'(ready_o), 32'd1);
    @(posedge clk_i);
    #1;
    send(OP_ADD, 23'd40, 23'd2, Q, 4'hE, 23'd42, 1'b0, 1'b1);
    idle();
    wait_drain("drain_postrst");

`ifdef MOD_ADDSUB_RANGE_CHECK_EN
    send(OP_ADD, Q, 23'd0, Q, 4'h1, 23'd0, 1'b1, 1'b0);
    send(OP_ADD, 23'd1, 23'd1, Q, 4'h2, 23'd2, 1'b0, 1'b1);
    idle();
    wait_drain("drain_err");
    @(negedge clk_i);
    chk("err_cleared", 32'(err_o), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
